// File: rtl/prescaler_multi_pkg.sv
// Shared definitions for the multi-channel prescaler.
//   state_e        per-channel FSM encoding (IDLE=0, RUN=1, DONE=2)
//   MODE_*         values of a channel's mode bit
//   CLK_PERIOD_NS  board clock period, for converting ns to cycles
//   DBG_W          width of the cnt_dbg observation port
package prescaler_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int CLK_PERIOD_NS = 40;
  localparam int DBG_W         = 16;

endpackage

// File: rtl/prescaler_multi_if.sv
// Signal bundle between the prescaler and its user.
// There is no valid/ready handshake here: every input is a level that is
// sampled on each rising clk edge, and every output is a registered level
// (tick is a one-cycle pulse) that may be sampled at any time between edges.
//   master: drives en, mode, period, sync_clr; observes tick, done, cnt_dbg, st_dbg
//   slave : the prescaler side (directions reversed)
interface prescaler_multi_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 16
);
  import prescaler_multi_pkg::*;

  logic [N_CH-1:0]       en;
  logic [N_CH-1:0]       mode;
  logic [N_CH*CNT_W-1:0] period;
  logic                  sync_clr;
  logic [N_CH-1:0]       tick;
  logic [N_CH-1:0]       done;
  logic [DBG_W-1:0]      cnt_dbg;
  state_e                st_dbg;   // FSM state of the debug channel

  modport master (
    output en, mode, period, sync_clr,
    input  tick, done, cnt_dbg, st_dbg
  );

  modport slave (
    input  en, mode, period, sync_clr,
    output tick, done, cnt_dbg, st_dbg
  );

endinterface

// File: rtl/prescaler_ch.sv
// One prescaler channel: counter, latched period, IDLE/RUN/DONE FSM and
// registered tick/done outputs.
//   clk, rst_n  clock, asynchronous active-low reset
//   en          level enable; low returns the channel to IDLE
//   mode        0 = periodic, 1 = one-shot (only looked at on a wrap)
//   sync_clr    zeroes the counter of a running channel
//   period      interval in clock cycles (0 behaves as 1)
//   tick        one-cycle pulse after the terminal count
//   done        one-shot finished, held until en drops
//   cnt         current counter value
//   state_o     current FSM state
module prescaler_ch
  import prescaler_multi_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic             sync_clr,
  input  logic [CNT_W-1:0] period,
  output logic             tick,
  output logic             done,
  output logic [CNT_W-1:0] cnt,
  output state_e           state_o
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] plat_q, plat_d;
  logic             tick_q, tick_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] plat_eff;
  logic [CNT_W-1:0] cnt_inc;
  logic             wrap;

  // A latched period of 0 counts as 1. The counter never exceeds
  // plat_eff-1 while running, so cnt_q+1 cannot overflow CNT_W bits.
  assign plat_eff = (plat_q == '0) ? ONE : plat_q;
  assign cnt_inc  = cnt_q + ONE;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    plat_d  = plat_q;
    tick_d  = 1'b0;
    done_d  = done_q;
    wrap    = 1'b0;

    if (!en) begin
      // Highest priority: also swallows a coinciding terminal count.
      state_d = ST_IDLE;
      cnt_d   = '0;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          // The enabling edge is the first counted edge.
          plat_d  = period;
          cnt_d   = ONE;
          state_d = ST_RUN;
          if (period <= ONE) wrap = 1'b1;
        end
        ST_RUN: begin
          if (sync_clr) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc >= plat_eff) wrap = 1'b1;
          end
        end
        ST_DONE: begin
          cnt_d  = '0;
          done_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          done_d  = 1'b0;
        end
      endcase

      // Terminal count: pulse, restart the interval with a freshly
      // sampled period, and let mode decide whether to keep running.
      if (wrap) begin
        tick_d = 1'b1;
        cnt_d  = '0;
        plat_d = period;
        if (mode == MODE_ONESHOT) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      plat_q  <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      plat_q  <= plat_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign tick    = tick_q;
  assign done    = done_q;
  assign cnt     = cnt_q;
  assign state_o = state_q;

endmodule

// File: rtl/prescaler_multi.sv
// Multi-channel runtime-programmable tick prescaler.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         prescaler_multi_if slave modport:
//                 en/mode       per-channel enable and mode
//                 period        packed periods, channel i at [i*CNT_W +: CNT_W]
//                 sync_clr      realigns every running channel
//                 tick/done     per-channel registered outputs
//                 cnt_dbg       counter of channel DBG_CH (zero-extended or truncated)
//                 st_dbg        FSM state of channel DBG_CH
module prescaler_multi
  import prescaler_multi_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 16,
  parameter int DBG_CH = 0
) (
  input logic              clk,
  input logic              rst_n,
  prescaler_multi_if.slave bus
);

  logic [CNT_W-1:0] cnt_all [N_CH];
  state_e           st_all  [N_CH];
  logic [N_CH-1:0]  tick_all;
  logic [N_CH-1:0]  done_all;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    prescaler_ch #(
      .CNT_W (CNT_W)
    ) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (bus.en[gi]),
      .mode     (bus.mode[gi]),
      .sync_clr (bus.sync_clr),
      .period   (bus.period[gi*CNT_W +: CNT_W]),
      .tick     (tick_all[gi]),
      .done     (done_all[gi]),
      .cnt      (cnt_all[gi]),
      .state_o  (st_all[gi])
    );
  end

  assign bus.tick   = tick_all;
  assign bus.done   = done_all;
  assign bus.st_dbg = st_all[DBG_CH];

  // Selecting a fixed channel is pure wiring, so cnt_dbg stays registered.
  if (CNT_W >= DBG_W) begin : g_dbg_trunc
    assign bus.cnt_dbg = cnt_all[DBG_CH][DBG_W-1:0];
  end else begin : g_dbg_ext
    assign bus.cnt_dbg = {{(DBG_W-CNT_W){1'b0}}, cnt_all[DBG_CH]};
  end

endmodule

// File: tb/tb_prescaler_multi.sv
module tb_prescaler_multi;
  import prescaler_multi_pkg::*;

  localparam int N_CH  = 4;
  localparam int CNT_W = 16;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #(CLK_PERIOD_NS / 2) clk = ~clk;

  prescaler_multi_if #(.N_CH(N_CH), .CNT_W(CNT_W)) bus ();

  prescaler_multi #(
    .N_CH   (N_CH),
    .CNT_W  (CNT_W),
    .DBG_CH (0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    exp_q.push_back(exp_v);
    total++;
    if (act !== exp_q.pop_front()) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    bus.en       = '0;
    bus.mode     = '0;
    bus.sync_clr = 1'b0;
    step();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        en;
    logic        mode;
    logic [15:0] per;
    logic        clr;
    logic        tick;
    logic        done;
    logic [15:0] cnt;
    logic [1:0]  st;
  } vec_t;

  vec_t vq[$];

  task automatic add_vec(input logic en, input logic mode, input logic [15:0] per,
                         input logic clr, input logic tick, input logic done,
                         input logic [15:0] cnt, input logic [1:0] st);
    vec_t v;
    v.en = en; v.mode = mode; v.per = per; v.clr = clr;
    v.tick = tick; v.done = done; v.cnt = cnt; v.st = st;
    vq.push_back(v);
  endtask

  task automatic build_table();
    // one-shot P=5, sync_clr ignored in DONE, then re-armed shot
    add_vec(0, 1, 5, 0, 0, 0, 0, 0);
    for (int e = 1; e <= 4; e++) add_vec(1, 1, 5, 0, 0, 0, 16'(e), 1);
    add_vec(1, 1, 5, 0, 1, 1, 0, 2);
    add_vec(1, 1, 5, 0, 0, 1, 0, 2);
    add_vec(1, 1, 5, 1, 0, 1, 0, 2);
    add_vec(0, 1, 5, 0, 0, 0, 0, 0);
    for (int e = 1; e <= 4; e++) add_vec(1, 1, 5, 0, 0, 0, 16'(e), 1);
    add_vec(1, 1, 5, 0, 1, 1, 0, 2);
    add_vec(1, 1, 5, 0, 0, 1, 0, 2);
    // periodic P=10, period changed to 3 on edge 4
    add_vec(0, 0, 10, 0, 0, 0, 0, 0);
    for (int e = 1; e <= 3; e++) add_vec(1, 0, 10, 0, 0, 0, 16'(e), 1);
    for (int e = 4; e <= 9; e++) add_vec(1, 0, 3, 0, 0, 0, 16'(e), 1);
    add_vec(1, 0, 3, 0, 1, 0, 0, 1);
    for (int r = 0; r < 2; r++) begin
      add_vec(1, 0, 3, 0, 0, 0, 1, 1);
      add_vec(1, 0, 3, 0, 0, 0, 2, 1);
      add_vec(1, 0, 3, 0, 1, 0, 0, 1);
    end
    // en=0 exactly on the terminal edge suppresses the tick
    add_vec(0, 0, 3, 0, 0, 0, 0, 0);
    add_vec(1, 0, 3, 0, 0, 0, 1, 1);
    add_vec(1, 0, 3, 0, 0, 0, 2, 1);
    add_vec(0, 0, 3, 0, 0, 0, 0, 0);
    // mode switched to one-shot mid-interval decides this wrap
    add_vec(1, 0, 3, 0, 0, 0, 1, 1);
    add_vec(1, 1, 3, 0, 0, 0, 2, 1);
    add_vec(1, 1, 3, 0, 1, 1, 0, 2);
    add_vec(0, 0, 3, 0, 0, 0, 0, 0);
    // sync_clr on the terminal edge, then a full interval from zero
    add_vec(1, 0, 3, 0, 0, 0, 1, 1);
    add_vec(1, 0, 3, 0, 0, 0, 2, 1);
    add_vec(1, 0, 3, 1, 0, 0, 0, 1);
    add_vec(1, 0, 3, 0, 0, 0, 1, 1);
    add_vec(1, 0, 3, 0, 0, 0, 2, 1);
    add_vec(1, 0, 3, 0, 1, 0, 0, 1);
    // en=0 wins over sync_clr
    add_vec(0, 0, 3, 1, 0, 0, 0, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #(CLK_PERIOD_NS * 5000);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    rst_n        = 1'b0;
    bus.en       = '0;
    bus.mode     = '0;
    bus.period   = '0;
    bus.sync_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tick",  32'(bus.tick),   0);
    check("rst_done",  32'(bus.done),   0);
    check("rst_cnt",   32'(bus.cnt_dbg), 0);
    check("rst_state", 32'(bus.st_dbg), 32'(ST_IDLE));
    @(negedge clk);
    rst_n = 1'b1;

    // Test 1: periodic P=50 on ch0
    bus.period[15:0] = 16'd50;
    bus.en[0] = 1'b1;
    for (int e = 1; e <= 150; e++) begin
      step();
      check($sformatf("t1_tick_e%0d", e), 32'(bus.tick[0]), 32'((e % 50) == 0));
      check($sformatf("t1_cnt_e%0d", e),  32'(bus.cnt_dbg), 32'(e % 50));
    end
    check("t1_done", 32'(bus.done[0]), 0);
    idle_all();
    check("t1_idle_state", 32'(bus.st_dbg), 32'(ST_IDLE));

    // Test 2: P=0 on ch0, P=1 on ch1
    bus.period[15:0]  = 16'd0;
    bus.period[31:16] = 16'd1;
    bus.en[1:0] = 2'b11;
    for (int e = 1; e <= 6; e++) begin
      step();
      check($sformatf("t2_tick_e%0d", e), 32'(bus.tick[1:0]), 3);
      check($sformatf("t2_done_e%0d", e), 32'(bus.done[1:0]), 0);
    end
    idle_all();
    check("t2_tick_off", 32'(bus.tick[1:0]), 0);

    // Table: one-shot, period change, en/mode/sync_clr corner cases on ch0
    build_table();
    for (int k = 0; k < vq.size(); k++) begin
      bus.en[0]        = vq[k].en;
      bus.mode[0]      = vq[k].mode;
      bus.period[15:0] = vq[k].per;
      bus.sync_clr     = vq[k].clr;
      step();
      check($sformatf("vec%0d_tick", k),  32'(bus.tick[0]),  32'(vq[k].tick));
      check($sformatf("vec%0d_done", k),  32'(bus.done[0]),  32'(vq[k].done));
      check($sformatf("vec%0d_cnt", k),   32'(bus.cnt_dbg),  32'(vq[k].cnt));
      check($sformatf("vec%0d_state", k), 32'(bus.st_dbg),   32'(vq[k].st));
    end
    idle_all();

    // Test 5: ch0 P=4, ch1 P=6, sync_clr on ch0's second wrap edge
    bus.period[15:0]  = 16'd4;
    bus.period[31:16] = 16'd6;
    bus.en[1:0] = 2'b11;
    for (int e = 1; e <= 7; e++) begin
      step();
      check($sformatf("t5_tick0_e%0d", e), 32'(bus.tick[0]), 32'((e % 4) == 0));
      check($sformatf("t5_tick1_e%0d", e), 32'(bus.tick[1]), 32'(e == 6));
    end
    bus.sync_clr = 1'b1;
    step();
    bus.sync_clr = 1'b0;
    check("t5_clr_tick", 32'(bus.tick[1:0]), 0);
    check("t5_clr_cnt",  32'(bus.cnt_dbg),   0);
    for (int k = 1; k <= 6; k++) begin
      step();
      check($sformatf("t5_post_tick0_%0d", k), 32'(bus.tick[0]), 32'(k == 4));
      check($sformatf("t5_post_tick1_%0d", k), 32'(bus.tick[1]), 32'(k == 6));
      check($sformatf("t5_post_cnt_%0d", k),   32'(bus.cnt_dbg), 32'(k % 4));
    end
    idle_all();

    // Test 6: asynchronous reset mid-count
    bus.period[15:0] = 16'd50;
    bus.en[0] = 1'b1;
    repeat (30) step();
    check("t6_cnt30", 32'(bus.cnt_dbg), 30);
    #10;
    rst_n = 1'b0;
    #1;
    check("t6_async_tick", 32'(bus.tick), 0);
    check("t6_async_done", 32'(bus.done), 0);
    check("t6_async_cnt",  32'(bus.cnt_dbg), 0);
    @(posedge clk);
    #10;
    rst_n = 1'b1;
    for (int e = 1; e <= 50; e++) begin
      step();
      check($sformatf("t6_tick_e%0d", e), 32'(bus.tick[0]), 32'(e == 50));
      check($sformatf("t6_cnt_e%0d", e),  32'(bus.cnt_dbg), 32'(e % 50));
    end
    idle_all();

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
